// File: rtl/alu_word_seq.sv
// alu_word_seq: multi-byte ALU that runs the 8-bit op set one byte per clock.
// Carries and shift bits chain across bytes, and Z is accumulated across all bytes.
module alu_word_seq #(
  parameter int BYTES = 2,
  localparam int W = 8 * BYTES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  input  logic         dec_add,
  input  logic         dec_sub,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         overflow_out,
  output logic         z_out,
  output logic         n_out
);
  localparam logic [2:0] ORA = 3'd0, AND = 3'd1, EOR = 3'd2, ADC = 3'd3,
                         SBC = 3'd4, SHL = 3'd5, SHR = 3'd6, ASR = 3'd7;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] op_q;
  logic [W-1:0] a_q, b_q, shd_q, shd_d, result_q;
  logic [1:0] idx_q, idx_d, pos;
  logic c_q, c_d, nz_q, nz_d, dadd_q, dsub_q;
  logic carry_q, ovf_q, z_q, n_q;
  logic [7:0] ab, bb, rb;
  logic [4:0] lo, hi;
  logic co, accept, last, finish;
  // Returns {carry, nibble}; decimal adjust wraps mod 16.
  function automatic logic [4:0] nib(input logic [3:0] x, input logic [3:0] y,
                                     input logic ci, input logic da, input logic ds);
    logic [4:0] s;
    logic cy;
    s = {1'b0, x} + {1'b0, y} + {4'b0, ci};
    cy = s[4] | (da & s[3] & (s[2] | s[1]));
    return {cy, s[3:0] + ((da & cy) ? 4'h6 : 4'h0) + ((ds & ~cy) ? 4'hA : 4'h0)};
  endfunction
  assign accept = start && state_q != RUN;
  assign last   = idx_q == 2'(BYTES - 1);
  assign finish = state_q == RUN && last;
  assign pos    = (op_q == SHR || op_q == ASR) ? 2'(BYTES - 1) - idx_q : idx_q;
  assign ab     = a_q[{pos, 3'b000} +: 8];
  assign bb     = b_q[{pos, 3'b000} +: 8];
  always_comb begin
    lo = nib(ab[3:0], bb[3:0], c_q, dadd_q, dsub_q);
    hi = nib(ab[7:4], bb[7:4], lo[4], dadd_q, dsub_q);
    rb = 8'h00;
    co = 1'b0;
    case (op_q)
      ORA:      rb = ab | bb;
      AND:      rb = ab & bb;
      EOR:      rb = ab ^ bb;
      ADC, SBC: {co, rb} = {hi[4], hi[3:0], lo[3:0]};
      SHL:      {co, rb} = {ab, c_q};
      SHR, ASR: {rb, co} = {c_q, ab};
      default:  rb = 8'h00;
    endcase
  end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shd_d   = shd_q;
    c_d     = c_q;
    nz_d    = nz_q;
    if (state_q == RUN) begin
      shd_d[{pos, 3'b000} +: 8] = rb;
      c_d     = co;
      nz_d    = nz_q | (|rb);
      idx_d   = idx_q + 2'd1;
      state_d = last ? DONE : RUN;
    end else if (accept) begin
      state_d = RUN;
      idx_d   = '0;
      shd_d   = '0;
      // ASR seeds the chain with the sign bit so it replicates into the MSB.
      c_d     = (op == ASR) ? a[W-1] : c_in;
      nz_d    = 1'b0;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shd_q    <= '0;
      c_q      <= 1'b0;
      nz_q     <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      dadd_q   <= 1'b0;
      dsub_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shd_q   <= shd_d;
      c_q     <= c_d;
      nz_q    <= nz_d;
      if (accept) begin
        op_q   <= op;
        a_q    <= a;
        b_q    <= b;
        dadd_q <= dec_add;
        dsub_q <= dec_sub;
      end
      if (finish) begin
        result_q <= shd_d;
        carry_q  <= (op_q == AND) ? nz_d : co;
        ovf_q    <= (op_q == ADC || op_q == SBC) && a_q[W-1] == b_q[W-1] && a_q[W-1] != shd_d[W-1];
        z_q      <= ~nz_d;
        n_q      <= shd_d[W-1];
      end
    end
  end
  assign busy         = state_q == RUN;
  assign done         = state_q == DONE;
  assign result       = result_q;
  assign carry_out    = carry_q;
  assign overflow_out = ovf_q;
  assign z_out        = z_q;
  assign n_out        = n_q;
endmodule

// File: doc/alu_word_seq.md
Name: alu_word_seq

Overview:
- Sequential multi-byte ALU engine for 16/24/32-bit word operations: word INC/DEC, word ADC/SBC, and multi-byte shifts.
- Reuses the 8-bit ALU op set (`kALU_*` codes from 6502_inc.vh) and processes one byte per clock.
- Carries, borrows and shift bits are chained across bytes; Z is accumulated across all bytes.
- Sits beside the core ALU. Operand muxing and SBC operand inversion are done by the caller, exactly as for the 8-bit unit.

Parameters:
- BYTES, 2, operand width in bytes (legal range 1..4); W = 8*BYTES.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only when busy=0
- op  input  3  `kALU_*` operation code, latched at accept
- a  input  W  operand A, latched at accept
- b  input  W  operand B, latched at accept (already inverted by caller for SBC)
- c_in  input  1  carry/shift-in bit, latched at accept
- dec_add  input  1  decimal adjust for addition, latched at accept
- dec_sub  input  1  decimal adjust for subtraction, latched at accept
- busy  output  1  high from the cycle after accept until done
- done  output  1  one-cycle pulse; result and flags valid
- result  output  W  word result
- carry_out  output  1  final carry/borrow/shift-out
- overflow_out  output  1  signed overflow
- z_out  output  1  result == 0 over all W bits
- n_out  output  1  result[W-1]

Behaviour:
- Reset (async, any state including mid-operation): state=IDLE; busy=0; done=0; result=0; all flags=0; in-flight operation discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 → latch inputs, byte index = first byte, go RUN.
  - RUN: one byte per cycle; after BYTES cycles go DONE.
  - DONE: done=1 for exactly one cycle. If start=1 in this cycle it is accepted (back-to-back) and the FSM goes RUN; otherwise IDLE.
- start while RUN is ignored; latched operands are unaffected.
- Latency: accept edge + BYTES cycles of RUN; done is high in cycle BYTES+1 after accept. Throughput is one op per BYTES+1 cycles.
- result and flags update only when entering DONE and hold until the next DONE. Intermediate bytes are built in an internal shadow register.
- Processing order:
  - LSB→MSB for ORA, AND, EOR, ADC, SBC and SHL.
  - MSB→LSB for SHR and ASR.
- ADC/SBC per byte, low nibble then high nibble:
  - 5-bit sum s = x + y + cin.
  - Nibble carry = s[4] | (dec_add & s[3] & (s[2] | s[1])).
  - If dec_add & carry: add 6 mod 16. If dec_sub & ~carry: add 0xA mod 16.
  - The high-nibble carry feeds the next byte's cin; the first byte uses c_in.
- overflow_out: computed from the MSB byte only, as (a[W-1]==b[W-1]) & (a[W-1]!=result[W-1]) after adjust. It is 0 for all non-ADC/SBC ops.
- SHL: c_in enters bit 0; each byte's bit 7 feeds the next byte's bit 0; carry_out = a[W-1].
- SHR: c_in enters bit W-1; carry_out = a[0].
- ASR: a[W-1] is replicated into bit W-1; carry_out = a[0].
- ORA/EOR: carry_out = 0.
- AND: carry_out = |result over the full word (branch-bit-test convention).
- z_out: sticky OR across bytes, equivalent to ~|result. n_out = result[W-1].
- BYTES=1 must behave byte-identically to the 8-bit ALU, with 2-cycle latency.
- Unknown/unused op codes: result=0, flags=0, normal timing.

Test Plan:
1. BYTES=2, ADC, a=0x12FF, b=0x0001, c_in=0, binary → done exactly 3 cycles after accept edge; result=0x1300, carry=0, V=0, Z=0, N=0; busy high 2 cycles.
2. Decimal: ADC dec_add=1, a=0x0999, b=0x0001, c_in=0 → result=0x1000, carry=0. SBC dec_sub=1, a=0x1000, b=0xFFFE, c_in=1 → result=0x0999, carry=1.
3. Flags: ADC a=0x7FFF, b=0x0001 → result=0x8000, V=1, N=1, Z=0. AND a=0x0100, b=0x00FF → result=0x0000, Z=1, carry=0.
4. Shifts: ASR a=0x8002 → 0xC001, carry=0. SHL a=0x8080, c_in=1 → 0x0101, carry=1. SHR a=0x0001, c_in=1 → 0x8000, carry=1.
5. Handshake: start held high continuously → accepts at IDLE and at each DONE, one done pulse per op; a start pulse during RUN is ignored and the result matches the first operands.
6. Reset asserted mid-RUN → busy, done, result and flags are 0 immediately (asynchronously). After release, a new op completes normally. Repeat scenarios 1–4 with BYTES=1 and BYTES=4 (e.g., ADC 0x00FFFFFF + 1 → 0x01000000, latency 5).
